// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch FSM state type. Imported by the fetch unit
// and the immediate generator.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FULL,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter: async reset to RESET_PC, +4 step, word-aligned redirect load.
module ifu_pc_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;

  // Load wins over increment; low two bits are dropped so fetches stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_pc & ~XLEN'(3);
    end else if (inc) begin
      pc_q <= pc_q + XLEN'(4);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage with redirect squash.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_squash_cnt
`endif
);

  import riscv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc;
  logic            pc_inc, pc_load;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            req_valid_q;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    fetch_addr_d = fetch_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) begin
          fetch_addr_d = pc;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = fetch_addr_q;
          valid_d    = 1'b1;
          pc_inc     = 1'b1;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; DRAIN only while a request is still in flight.
    if (redirect_valid) begin
      pc_load    = 1'b1;
      pc_inc     = 1'b0;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      instr_pc_d = instr_pc_q;
      unique case (state_q)
        REQ:     state_d = imem_req_ready ? DRAIN : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : DRAIN;
        DRAIN:   state_d = imem_rsp_valid ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= RESET_PC;
      valid_q      <= 1'b0;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      req_valid_q  <= (state_d == REQ);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = valid_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, squash_cnt_q;
  logic        squash;

  assign squash = redirect_valid &&
                  ((state_q == FULL) || ((state_q != DRAIN) && (state_d == DRAIN)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (valid_q && instr_ready && !redirect_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (squash) squash_cnt_q <= squash_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (counter checks need IFU_PERF_CNT_EN).
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a REQ cycle: accept the request, return data next cycle; ends in FULL.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    step();
    step();
    check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);

    // Basic fetch with zero-wait memory.
    rst = 1'b0;
    imem_req_ready = 1'b1;
    step();
    check_eq("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_eq("c1_addr", imem_addr, 32'h0);
    step();
    imem_req_ready = 1'b0;
    check_eq("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    check_eq("f1_instr", instr, 32'h0050_0093);
    check_eq("f1_pc", instr_pc, 32'h0);
    check_eq("f1_valid", {31'd0, instr_valid}, 32'd1);

    // Backpressure: output held and no new request.
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_instr", instr, 32'h0050_0093);
      check_eq("hold_pc", instr_pc, 32'h0);
      check_eq("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    consume();
    check_eq("cons_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("cons_instr", instr, NOP);
    check_eq("cons_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_eq("cons_addr", imem_addr, 32'h4);

    // Redirect while waiting: DRAIN, squashed response, then fetch at 0x100.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_to(32'h0000_0103);
    step();
    redirect_valid = 1'b0;
    check_eq("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_beef;
    step();
    imem_rsp_valid = 1'b0;
    check_eq("drain_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("drain_req", {31'd0, imem_req_valid}, 32'd1);
    check_eq("drain_addr", imem_addr, 32'h100);
    fetch(32'h00a0_0113);
    check_eq("rd_instr", instr, 32'h00a0_0113);
    check_eq("rd_pc", instr_pc, 32'h100);
    check_eq("rd_valid", {31'd0, instr_valid}, 32'd1);

    // Redirect together with instr_ready in FULL: instruction dropped.
    instr_ready = 1'b1;
    redirect_to(32'h200);
    step();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    check_eq("full_rd_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("full_rd_instr", instr, NOP);
    check_eq("full_rd_addr", imem_addr, 32'h200);
    check_eq("full_rd_req", {31'd0, imem_req_valid}, 32'd1);

    // Redirect together with the response: response discarded, straight to REQ.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    redirect_to(32'h300);
    step();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    check_eq("rsp_rd_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rsp_rd_addr", imem_addr, 32'h300);
    check_eq("rsp_rd_req", {31'd0, imem_req_valid}, 32'd1);

    // Redirect in REQ without ready retracts the address.
    redirect_to(32'h400);
    step();
    redirect_valid = 1'b0;
    check_eq("req_rd_req", {31'd0, imem_req_valid}, 32'd1);
    check_eq("req_rd_addr", imem_addr, 32'h400);

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0010_0073);
    check_eq("wrap_instr", instr, 32'h0010_0073);
    check_eq("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    consume();
    check_eq("wrap_addr1", imem_addr, 32'h0);

    // Asynchronous reset in the middle of WAIT.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("arst_instr", instr, NOP);
    check_eq("arst_pc", instr_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check_eq("arst_fetch_cnt", perf_fetch_cnt, 32'd0);
    check_eq("arst_squash_cnt", perf_squash_cnt, 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    check_eq("rr_addr", imem_addr, 32'h0);
    fetch(32'h0000_0001);
    consume();
    fetch(32'h0000_0002);
    consume();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_to(32'h80);
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    check_eq("rr_redir_addr", imem_addr, 32'h80);
    fetch(32'h0000_0003);
    check_eq("rr_pc3", instr_pc, 32'h80);
    consume();
    check_eq("rr_next_addr", imem_addr, 32'h84);
`ifdef IFU_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, 32'd3);
    check_eq("perf_squash", perf_squash_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
